// File: rtl/gate_truth_bist_pkg.sv
// Shared types and helpers for the exhaustive gate truth-table BIST.
package gate_truth_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/gate_truth_bist_if.sv
// BIST-to-gate bus: stimulus vector, gate response, run status and per-vector log.
interface gate_truth_bist_if #(
  parameter int unsigned N_IN = 2
);
  logic            START;
  logic [N_IN-1:0] A_OUT;
  logic            Y_IN;
  logic            BUSY;
  logic            DONE;
  logic            PASS;
  logic [N_IN:0]   ERR_CNT;
  logic [N_IN-1:0] FAIL_VEC;
  logic            LOG_VALID;
  logic [N_IN-1:0] LOG_VEC;
  logic            LOG_Y;
  logic            LOG_ERR;

  modport master (
    output START, Y_IN,
    input  A_OUT, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC,
    input  LOG_VALID, LOG_VEC, LOG_Y, LOG_ERR
  );

  modport slave (
    input  START, Y_IN,
    output A_OUT, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC,
    output LOG_VALID, LOG_VEC, LOG_Y, LOG_ERR
  );
endinterface

// File: rtl/gate_truth_bist_settle_timer.sv
// Settle-time down-counter: load, decrement while enabled, flag when zero.
module bist_settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                       r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/gate_truth_bist.sv
// Exhaustive truth-table driver/checker for a small combinational gate.
module gate_truth_bist
  import gate_truth_bist_pkg::*;
#(
  parameter int unsigned              N_IN   = 2,
  parameter int unsigned              SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]     EXP_TT = 4'b1000
) (
  input  logic              CLK,
  input  logic              RST,
  gate_truth_bist_if.slave  io
);
  localparam int unsigned TW = $clog2(SETTLE) + 1;

  state_t          r_state, w_next;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_fail_vec;
  logic            r_done, r_pass;
  logic            r_log_valid, r_log_y, r_log_err;
  logic [N_IN-1:0] r_log_vec;

  logic            w_idle_like, w_start, w_last, w_mis, w_zero, w_load, w_dec;
  logic [N_IN:0]   w_err_nxt;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_FIN);
  assign w_start     = w_idle_like && io.START;
  assign w_last      = (r_vec == '1);
  // Case-inequality so an X/Z response is scored as a mismatch.
  assign w_mis       = (io.Y_IN !== EXP_TT[r_vec]);
  assign w_err_nxt   = r_err_cnt + {{N_IN{1'b0}}, w_mis};
  assign w_load      = w_start || ((r_state == S_SAMPLE) && !w_last);
  assign w_dec       = (r_state == S_SETTLE);

  bist_settle_timer #(.W(TW)) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (w_load),
    .i_load_val (TW'(SETTLE - 1)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FIN: if (io.START) w_next = S_SETTLE;
      S_SETTLE:      if (w_zero)   w_next = S_SAMPLE;
      S_SAMPLE:      w_next = w_last ? S_FIN : S_SETTLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vec       <= '0;
      r_err_cnt   <= '0;
      r_fail_vec  <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_log_valid <= 1'b0;
      r_log_vec   <= '0;
      r_log_y     <= 1'b0;
      r_log_err   <= 1'b0;
    end else begin
      r_log_valid <= 1'b0;
      if (w_start) begin
        r_vec      <= '0;
        r_err_cnt  <= '0;
        r_fail_vec <= '0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
      end else if (r_state == S_SAMPLE) begin
        r_log_valid <= 1'b1;
        r_log_vec   <= r_vec;
        r_log_y     <= io.Y_IN;
        r_log_err   <= w_mis;
        r_err_cnt   <= w_err_nxt;
        if (w_mis && r_err_cnt == '0) r_fail_vec <= r_vec;
        if (w_last) begin
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == '0);
        end else begin
          r_vec <= r_vec + 1'b1;
        end
      end
    end
  end

  // A_OUT tracks the vector counter directly; it holds the last vector in FIN.
  assign io.A_OUT     = r_vec;
  assign io.BUSY      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign io.DONE      = r_done;
  assign io.PASS      = r_pass;
  assign io.ERR_CNT   = r_err_cnt;
  assign io.FAIL_VEC  = r_fail_vec;
  assign io.LOG_VALID = r_log_valid;
  assign io.LOG_VEC   = r_log_vec;
  assign io.LOG_Y     = r_log_y;
  assign io.LOG_ERR   = r_log_err;
endmodule
